// File: rtl/huffman_table_decoder_pkg.sv
// Shared types for the canonical Huffman decoder: FSM states, per-length
// descriptor layout and the JPEG table IDs.
package huffman_pkg;
    localparam int HUF_CODE_W = 16;

    localparam int TBL_DC_Y = 0;
    localparam int TBL_AC_Y = 1;
    localparam int TBL_DC_C = 2;
    localparam int TBL_AC_C = 3;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LOOKUP  = 2'd1,
        EMIT    = 2'd2,
        ERROR   = 2'd3
    } dec_state_t;

    typedef struct packed {
        logic                  valid;
        logic [HUF_CODE_W-1:0] mincode;
        logic [HUF_CODE_W-1:0] maxcode;
        logic [HUF_CODE_W-1:0] valptr;
    } len_desc_t;
endpackage

// File: rtl/huffman_table_decoder_if.sv
// Bit stream in / symbol stream out of the Huffman decoder.
// master = upstream bit source plus downstream symbol sink; slave = decoder.
interface huffman_table_decoder_if #(
    parameter int NUM_TABLES = 4,
    parameter int SYM_W      = 8,
    localparam int TW        = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
);
    logic [TW-1:0]    table_sel_in;
    logic             bit_in;
    logic             bit_valid_in;
    logic             bit_ready_out;
    logic [SYM_W-1:0] sym_out;
    logic [4:0]       codesize_out;
    logic             sym_valid_out;
    logic             sym_ready_in;

    modport master (
        output table_sel_in, bit_in, bit_valid_in, sym_ready_in,
        input  bit_ready_out, sym_out, codesize_out, sym_valid_out
    );

    modport slave (
        input  table_sel_in, bit_in, bit_valid_in, sym_ready_in,
        output bit_ready_out, sym_out, codesize_out, sym_valid_out
    );
endinterface

// File: rtl/huffman_table_decoder_len_match.sv
// Per-length canonical code compare and symbol index for the selected table.
// Latency: combinational. No handshake; caller qualifies the result.
// Unused descriptor fields are ignored when the length is not valid.
module huffman_len_match
    import huffman_pkg::*;
#(
    parameter int MAX_CODE_LEN = 16,
    parameter int AW           = 8
) (
    input  len_desc_t [MAX_CODE_LEN:1] desc_tbl,
    input  logic [HUF_CODE_W-1:0]      nc,
    input  logic [4:0]                 nl,
    output logic                       match,
    output logic [AW-1:0]              sym_addr
);
    len_desc_t             sel;
    logic [HUF_CODE_W-1:0] offset;

    always_comb begin
        sel = '0;
        for (int l = 1; l <= MAX_CODE_LEN; l++) begin
            if (nl == 5'(l)) sel = desc_tbl[l];
        end
        // nc carries no bits above nl, so a full-width compare is exact
        match    = sel.valid && (nc <= sel.maxcode);
        offset   = sel.valptr + (nc - sel.mincode);
        sym_addr = AW'(offset);
    end
endmodule

// File: rtl/xilinx_single_port_ram_read_first.sv
// Single-port read-first block RAM with a registered output.
// Latency: 1 cycle from enabled address to douta. No backpressure.
// Output holds its value while ena is low.
module xilinx_single_port_ram_read_first #(
    parameter int RAM_WIDTH = 8,
    parameter int RAM_DEPTH = 256,
    localparam int AW       = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                 clka,
    input  logic                 ena,
    input  logic                 wea,
    input  logic [AW-1:0]        addra,
    input  logic [RAM_WIDTH-1:0] dina,
    output logic [RAM_WIDTH-1:0] douta
);
    logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] dout_d, dout_q;

    always_comb begin
        dout_d = dout_q;
        if (ena) dout_d = mem_q[addra];
    end

    always_ff @(posedge clka) begin
        if (ena && wea) mem_q[addra] <= dina;
        dout_q <= dout_d;
    end

    assign douta = dout_q;
endmodule

// File: rtl/huffman_table_decoder.sv
// Bit-serial canonical Huffman decoder with runtime-loadable MINCODE/MAXCODE/VALPTR tables.
// Latency: symbol valid 2 cycles after the last code bit is accepted.
// Backpressure: holds the symbol and refuses bits until sym_ready_in; config writes dropped while busy.
module huffman_table_decoder
    import huffman_pkg::*;
#(
    parameter int MAX_CODE_LEN = 16,
    parameter int NUM_TABLES   = 4,
    parameter int SYM_DEPTH    = 256,
    parameter int SYM_W        = 8,
    localparam int TW          = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1,
    localparam int AW          = (SYM_DEPTH > 1) ? $clog2(SYM_DEPTH) : 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    cfg_len_we_in,
    input  logic                    cfg_sym_we_in,
    input  logic [TW-1:0]           cfg_table_in,
    input  logic [4:0]              cfg_len_in,
    input  logic                    cfg_len_valid_in,
    input  logic [MAX_CODE_LEN-1:0] cfg_mincode_in,
    input  logic [MAX_CODE_LEN-1:0] cfg_maxcode_in,
    input  logic [AW-1:0]           cfg_valptr_in,
    input  logic [AW-1:0]           cfg_sym_addr_in,
    input  logic [SYM_W-1:0]        cfg_sym_data_in,
    huffman_table_decoder_if.slave  dec_if,
    input  logic                    flush_in,
    output logic                    busy_out,
    output logic                    err_out
);
    len_desc_t [MAX_CODE_LEN:1] desc_d [NUM_TABLES];
    len_desc_t [MAX_CODE_LEN:1] desc_q [NUM_TABLES];
    len_desc_t [MAX_CODE_LEN:1] row;

    dec_state_t              state_d, state_q;
    logic [HUF_CODE_W-2:0]   code_d, code_q;
    logic [4:0]              len_d, len_q, size_d, size_q;
    logic [TW-1:0]           tbl_d, tbl_q, cur_tbl;
    logic [AW-1:0]           addr_d, addr_q, match_addr;
    logic [HUF_CODE_W-1:0]   nc;
    logic [4:0]              nl;
    logic                    match, len_wr, sym_wr;
    logic [SYM_W-1:0]        ram_dout [NUM_TABLES];
    logic [SYM_W-1:0]        sym_sel;

    assign busy_out = (len_q != 5'd0) || (state_q != COLLECT);
    assign len_wr   = cfg_len_we_in && !busy_out;
    assign sym_wr   = cfg_sym_we_in && !busy_out;

    always_comb begin
        desc_d = desc_q;
        for (int t = 0; t < NUM_TABLES; t++) begin
            for (int l = 1; l <= MAX_CODE_LEN; l++) begin
                if (len_wr && cfg_table_in == TW'(t) && cfg_len_in == 5'(l)) begin
                    desc_d[t][l] = '{valid:   cfg_len_valid_in,
                                     mincode: HUF_CODE_W'(cfg_mincode_in),
                                     maxcode: HUF_CODE_W'(cfg_maxcode_in),
                                     valptr:  HUF_CODE_W'(cfg_valptr_in)};
                end
            end
        end
    end

    // Table contents survive reset; only the length-valid flags are cleared.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int t = 0; t < NUM_TABLES; t++) begin
                for (int l = 1; l <= MAX_CODE_LEN; l++) desc_q[t][l].valid <= 1'b0;
            end
        end else begin
            desc_q <= desc_d;
        end
    end

    // The first bit of a code compares against the table being selected now.
    assign cur_tbl = (len_q == 5'd0) ? dec_if.table_sel_in : tbl_q;
    assign nc      = {code_q, dec_if.bit_in};
    assign nl      = len_q + 5'd1;

    always_comb begin
        row = '0;
        for (int t = 0; t < NUM_TABLES; t++) begin
            if (cur_tbl == TW'(t)) row = desc_q[t];
        end
    end

    huffman_len_match #(
        .MAX_CODE_LEN (MAX_CODE_LEN),
        .AW           (AW)
    ) u_len_match (
        .desc_tbl (row),
        .nc       (nc),
        .nl       (nl),
        .match    (match),
        .sym_addr (match_addr)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        len_d   = len_q;
        tbl_d   = tbl_q;
        addr_d  = addr_q;
        size_d  = size_q;
        if (flush_in) begin
            state_d = COLLECT;
            code_d  = '0;
            len_d   = '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (dec_if.bit_valid_in) begin
                        if (len_q == 5'd0) tbl_d = dec_if.table_sel_in;
                        if (match) begin
                            addr_d  = match_addr;
                            size_d  = nl;
                            state_d = LOOKUP;
                        end else if (nl == 5'(MAX_CODE_LEN)) begin
                            state_d = ERROR;
                        end else begin
                            code_d = nc[HUF_CODE_W-2:0];
                            len_d  = nl;
                        end
                    end
                end
                LOOKUP: state_d = EMIT;
                EMIT: begin
                    if (dec_if.sym_ready_in) begin
                        state_d = COLLECT;
                        code_d  = '0;
                        len_d   = '0;
                    end
                end
                default: state_d = ERROR;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= COLLECT;
            code_q  <= '0;
            len_q   <= '0;
            tbl_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            len_q   <= len_d;
            tbl_q   <= tbl_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
        end
    end

    // Writes only happen while idle and reads only in LOOKUP, so the ports never collide.
    for (genvar t = 0; t < NUM_TABLES; t++) begin : g_ram
        logic          we, en;
        logic [AW-1:0] addr;
        assign we   = sym_wr && (cfg_table_in == TW'(t));
        assign en   = we || ((state_q == LOOKUP) && (tbl_q == TW'(t)));
        assign addr = we ? cfg_sym_addr_in : addr_q;

        xilinx_single_port_ram_read_first #(
            .RAM_WIDTH (SYM_W),
            .RAM_DEPTH (SYM_DEPTH)
        ) u_ram (
            .clka  (clk_in),
            .ena   (en),
            .wea   (we),
            .addra (addr),
            .dina  (cfg_sym_data_in),
            .douta (ram_dout[t])
        );
    end

    always_comb begin
        sym_sel = '0;
        for (int t = 0; t < NUM_TABLES; t++) begin
            if (tbl_q == TW'(t)) sym_sel = ram_dout[t];
        end
    end

    assign dec_if.bit_ready_out = (state_q == COLLECT);
    assign dec_if.sym_valid_out = (state_q == EMIT);
    assign dec_if.sym_out       = (state_q == EMIT) ? sym_sel : '0;
    assign dec_if.codesize_out  = (state_q == EMIT) ? size_q : 5'd0;
    assign err_out              = (state_q == ERROR);
endmodule

// File: tb/tb_huffman_table_decoder.sv
// Directed bench for huffman_table_decoder using standard JPEG luma tables.
module tb_huffman_table_decoder;
    import huffman_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        cfg_len_we_in, cfg_sym_we_in, cfg_len_valid_in;
    logic [1:0]  cfg_table_in;
    logic [4:0]  cfg_len_in;
    logic [15:0] cfg_mincode_in, cfg_maxcode_in;
    logic [7:0]  cfg_valptr_in, cfg_sym_addr_in, cfg_sym_data_in;
    logic        flush_in, busy_out, err_out;

    int n_cmp  = 0;
    int n_fail = 0;

    int ac_bits [16] = '{0, 2, 1, 3, 3, 2, 4, 3, 5, 5, 4, 4, 0, 0, 1, 125};
    int dc_bits [16] = '{0, 1, 5, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    logic [7:0] ac_vals [11] = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h04, 8'h11,
                                 8'h05, 8'h12, 8'h21, 8'h31, 8'h41};

    always #5 clk_in = ~clk_in;

    huffman_table_decoder_if #(.NUM_TABLES(4), .SYM_W(8)) dif ();

    huffman_table_decoder #(
        .MAX_CODE_LEN (16),
        .NUM_TABLES   (4),
        .SYM_DEPTH    (256),
        .SYM_W        (8)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .cfg_len_we_in    (cfg_len_we_in),
        .cfg_sym_we_in    (cfg_sym_we_in),
        .cfg_table_in     (cfg_table_in),
        .cfg_len_in       (cfg_len_in),
        .cfg_len_valid_in (cfg_len_valid_in),
        .cfg_mincode_in   (cfg_mincode_in),
        .cfg_maxcode_in   (cfg_maxcode_in),
        .cfg_valptr_in    (cfg_valptr_in),
        .cfg_sym_addr_in  (cfg_sym_addr_in),
        .cfg_sym_data_in  (cfg_sym_data_in),
        .dec_if           (dif),
        .flush_in         (flush_in),
        .busy_out         (busy_out),
        .err_out          (err_out)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_len(input int tbl, input int l, input int v, input int mn, input int mx, input int vp);
        cfg_table_in     = 2'(tbl);
        cfg_len_in       = 5'(l);
        cfg_len_valid_in = 1'(v);
        cfg_mincode_in   = 16'(mn);
        cfg_maxcode_in   = 16'(mx);
        cfg_valptr_in    = 8'(vp);
        cfg_len_we_in    = 1'b1;
        tick();
        cfg_len_we_in    = 1'b0;
    endtask

    task automatic cfg_sym(input int tbl, input int addr, input logic [7:0] data);
        cfg_table_in    = 2'(tbl);
        cfg_sym_addr_in = 8'(addr);
        cfg_sym_data_in = data;
        cfg_sym_we_in   = 1'b1;
        tick();
        cfg_sym_we_in   = 1'b0;
    endtask

    // Derives JPEG MINCODE/MAXCODE/VALPTR from the BITS counts.
    task automatic load_canon(input int tbl, input int bits [16]);
        int code = 0;
        int ptr  = 0;
        for (int l = 1; l <= 16; l++) begin
            if (bits[l-1] > 0) begin
                cfg_len(tbl, l, 1, code, code + bits[l-1] - 1, ptr);
                ptr  += bits[l-1];
                code += bits[l-1];
            end
            code = code << 1;
        end
    endtask

    task automatic send_bit(input logic b, input int tsel);
        int n = 0;
        dif.bit_in       = b;
        dif.table_sel_in = 2'(tsel);
        dif.bit_valid_in = 1'b1;
        while (!dif.bit_ready_out && n < 30) begin
            tick();
            n++;
        end
        if (!dif.bit_ready_out) chk("bit_ready_timeout", 32'(dif.bit_ready_out), 32'd1);
        tick();
        dif.bit_valid_in = 1'b0;
    endtask

    task automatic wait_sym(input logic [7:0] es, input logic [4:0] el, input string tag);
        int n = 0;
        while (!dif.sym_valid_out && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, 32'(dif.sym_valid_out), 32'd1);
        chk({tag, "_sym"}, 32'(dif.sym_out), 32'(es));
        chk({tag, "_len"}, 32'(dif.codesize_out), 32'(el));
        dif.sym_ready_in = 1'b1;
        tick();
        dif.sym_ready_in = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1;
        cfg_len_we_in = 1'b0; cfg_sym_we_in = 1'b0; cfg_len_valid_in = 1'b0;
        cfg_table_in = '0; cfg_len_in = '0; cfg_mincode_in = '0; cfg_maxcode_in = '0;
        cfg_valptr_in = '0; cfg_sym_addr_in = '0; cfg_sym_data_in = '0;
        flush_in = 1'b0;
        dif.bit_in = 1'b0; dif.bit_valid_in = 1'b0; dif.table_sel_in = '0; dif.sym_ready_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b0;

        chk("rst_bit_ready", 32'(dif.bit_ready_out), 32'd1);
        chk("rst_sym_valid", 32'(dif.sym_valid_out), 32'd0);
        chk("rst_sym_out",   32'(dif.sym_out),       32'd0);
        chk("rst_codesize",  32'(dif.codesize_out),  32'd0);
        chk("rst_err",       32'(err_out),           32'd0);
        chk("rst_busy",      32'(busy_out),          32'd0);

        // Test 1: AC-luma in table 1, code 00 -> 0x01, 2-cycle latency
        load_canon(TBL_AC_Y, ac_bits);
        for (int i = 0; i < 11; i++) cfg_sym(TBL_AC_Y, i, ac_vals[i]);
        send_bit(1'b0, TBL_AC_Y);
        chk("t1_busy_partial", 32'(busy_out), 32'd1);
        send_bit(1'b0, TBL_AC_Y);
        chk("t1_lat_cyc1_vld", 32'(dif.sym_valid_out), 32'd0);
        tick();
        chk("t1_lat_cyc2_vld", 32'(dif.sym_valid_out), 32'd1);
        wait_sym(8'h01, 5'd2, "t1");
        chk("t1_idle_busy", 32'(busy_out), 32'd0);

        // Test 2: 1010 (EOB) stalled 5 cycles, then 1100 -> 0x11
        send_bit(1'b1, TBL_AC_Y); send_bit(1'b0, TBL_AC_Y);
        send_bit(1'b1, TBL_AC_Y); send_bit(1'b0, TBL_AC_Y);
        tick();
        dif.bit_in = 1'b1;
        dif.bit_valid_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_stall_vld",   32'(dif.sym_valid_out), 32'd1);
            chk("t2_stall_sym",   32'(dif.sym_out),       32'h00);
            chk("t2_stall_len",   32'(dif.codesize_out),  32'd4);
            chk("t2_stall_ready", 32'(dif.bit_ready_out), 32'd0);
            tick();
        end
        dif.bit_valid_in = 1'b0;
        wait_sym(8'h00, 5'd4, "t2a");
        send_bit(1'b1, TBL_AC_Y); send_bit(1'b1, TBL_AC_Y);
        send_bit(1'b0, TBL_AC_Y); send_bit(1'b0, TBL_AC_Y);
        wait_sym(8'h11, 5'd4, "t2b");

        // Test 3: DC-luma in table 0; table_sel changes mid-code are ignored
        load_canon(TBL_DC_Y, dc_bits);
        for (int i = 0; i < 12; i++) cfg_sym(TBL_DC_Y, i, 8'(i));
        send_bit(1'b0, TBL_DC_Y);
        send_bit(1'b1, TBL_AC_Y);
        send_bit(1'b0, TBL_AC_Y);
        wait_sym(8'h01, 5'd3, "t3a");
        send_bit(1'b0, TBL_AC_Y); send_bit(1'b0, TBL_AC_Y);
        wait_sym(8'h01, 5'd2, "t3b");

        // Test 4: only length 2 valid with maxcode 0; sixteen ones -> error
        cfg_len(TBL_AC_C, 2, 1, 0, 0, 0);
        cfg_sym(TBL_AC_C, 0, 8'h5A);
        for (int i = 0; i < 15; i++) send_bit(1'b1, TBL_AC_C);
        chk("t4_err_before_16", 32'(err_out), 32'd0);
        send_bit(1'b1, TBL_AC_C);
        chk("t4_err_at_16",   32'(err_out),           32'd1);
        chk("t4_ready_err",   32'(dif.bit_ready_out), 32'd0);
        tick();
        chk("t4_err_sticky",  32'(err_out),           32'd1);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        chk("t4_flush_err",   32'(err_out),           32'd0);
        chk("t4_flush_ready", 32'(dif.bit_ready_out), 32'd1);
        chk("t4_flush_busy",  32'(busy_out),          32'd0);
        send_bit(1'b0, TBL_AC_C); send_bit(1'b0, TBL_AC_C);
        wait_sym(8'h5A, 5'd2, "t4");

        // Test 5: symbol write while a partial code is held is dropped
        send_bit(1'b0, TBL_AC_Y);
        chk("t5_busy", 32'(busy_out), 32'd1);
        cfg_sym(TBL_AC_Y, 0, 8'hEE);
        send_bit(1'b0, TBL_AC_Y);
        wait_sym(8'h01, 5'd2, "t5a");
        send_bit(1'b0, TBL_AC_Y); send_bit(1'b0, TBL_AC_Y);
        wait_sym(8'h01, 5'd2, "t5b");

        // Test 6: reset during EMIT drops the symbol and clears valid flags
        send_bit(1'b0, TBL_AC_Y); send_bit(1'b0, TBL_AC_Y);
        tick();
        chk("t6_in_emit", 32'(dif.sym_valid_out), 32'd1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("t6_rst_vld",   32'(dif.sym_valid_out), 32'd0);
        chk("t6_rst_ready", 32'(dif.bit_ready_out), 32'd1);
        chk("t6_rst_sym",   32'(dif.sym_out),       32'd0);
        chk("t6_rst_busy",  32'(busy_out),          32'd0);
        for (int i = 0; i < 15; i++) send_bit(1'b0, TBL_AC_Y);
        chk("t6_err_before_16", 32'(err_out), 32'd0);
        chk("t6_no_sym",        32'(dif.sym_valid_out), 32'd0);
        send_bit(1'b0, TBL_AC_Y);
        chk("t6_err_at_16", 32'(err_out), 32'd1);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        chk("t6_flush_err", 32'(err_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
